// File: rtl/thunderbolt_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : thunderbolt_reg_arbiter
// Brief    : Round-robin read arbiter for the Thunderbolt time register bank.
//            Sequences byte/burst reads for two requesters over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module thunderbolt_reg_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_a,
    input  logic              i_req_b,
    input  logic [ADDR_W-1:0] i_addr_a,
    input  logic [ADDR_W-1:0] i_addr_b,
    input  logic [3:0]        i_len_a,
    input  logic [3:0]        i_len_b,
    output logic              o_gnt_a,
    output logic              o_gnt_b,
    output logic              o_rsp_valid_a,
    output logic              o_rsp_valid_b,
    input  logic              i_rsp_ready_a,
    input  logic              i_rsp_ready_b,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_last,
    output logic              o_busy,
    output logic              o_reg_wr,
    output logic [ADDR_W-1:0] o_reg_addr,
    input  logic [DATA_W-1:0] i_reg_data
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_HOLD    = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;

    logic              r_owner_b;
    logic              r_ptr_b;
    logic [4:0]        r_remaining;
    logic [ADDR_W-1:0] r_cur_addr;
    logic              r_gnt_a;
    logic              r_gnt_b;
    logic              r_valid_a;
    logic              r_valid_b;
    logic              r_last;
    logic              r_busy;
    logic [DATA_W-1:0] r_data;

    logic              w_owner_n;
    logic              w_ptr_n;
    logic [4:0]        w_remaining_n;
    logic [ADDR_W-1:0] w_cur_addr_n;
    logic              w_gnt_a_n;
    logic              w_gnt_b_n;
    logic              w_valid_a_n;
    logic              w_valid_b_n;
    logic              w_last_n;
    logic              w_busy_n;
    logic [DATA_W-1:0] w_data_n;

    logic              w_any_req;
    logic              w_pick_b;
    logic              w_owner_ready;
    logic [3:0]        w_len_sel;

    assign w_any_req     = i_req_a | i_req_b;
    // B wins when it is alone, or when both request and the pointer names B
    assign w_pick_b      = i_req_b & (~i_req_a | r_ptr_b);
    assign w_owner_ready = r_owner_b ? i_rsp_ready_b : i_rsp_ready_a;
    assign w_len_sel     = w_pick_b ? i_len_b : i_len_a;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_any_req) w_state_next = S_ISSUE;
            S_ISSUE:   w_state_next = S_CAPTURE;
            S_CAPTURE: w_state_next = S_HOLD;
            S_HOLD: begin
                if (w_owner_ready) begin
                    w_state_next = r_last ? S_IDLE : S_ISSUE;
                end
            end
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Output/datapath next values; every output is registered below
    always_comb begin
        w_owner_n     = r_owner_b;
        w_ptr_n       = r_ptr_b;
        w_remaining_n = r_remaining;
        w_cur_addr_n  = r_cur_addr;
        w_gnt_a_n     = 1'b0;
        w_gnt_b_n     = 1'b0;
        w_valid_a_n   = r_valid_a;
        w_valid_b_n   = r_valid_b;
        w_last_n      = r_last;
        w_busy_n      = r_busy;
        w_data_n      = r_data;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_gnt_a_n     = ~w_pick_b;
                    w_gnt_b_n     = w_pick_b;
                    w_owner_n     = w_pick_b;
                    w_ptr_n       = ~w_pick_b;
                    w_cur_addr_n  = w_pick_b ? i_addr_b : i_addr_a;
                    w_remaining_n = (w_len_sel == 4'd0) ? 5'd16 : {1'b0, w_len_sel};
                    w_busy_n      = 1'b1;
                end
            end
            S_CAPTURE: begin
                w_data_n    = i_reg_data;
                w_valid_a_n = ~r_owner_b;
                w_valid_b_n = r_owner_b;
                w_last_n    = (r_remaining == 5'd1);
            end
            S_HOLD: begin
                if (w_owner_ready) begin
                    w_valid_a_n = 1'b0;
                    w_valid_b_n = 1'b0;
                    w_last_n    = 1'b0;
                    if (r_last) begin
                        w_busy_n = 1'b0;
                    end else begin
                        w_cur_addr_n  = r_cur_addr + ADDR_W'(1);
                        w_remaining_n = r_remaining - 5'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_owner_b   <= 1'b0;
            r_ptr_b     <= 1'b0;
            r_remaining <= 5'd0;
            r_cur_addr  <= '0;
            r_gnt_a     <= 1'b0;
            r_gnt_b     <= 1'b0;
            r_valid_a   <= 1'b0;
            r_valid_b   <= 1'b0;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
            r_data      <= '0;
        end else begin
            r_owner_b   <= w_owner_n;
            r_ptr_b     <= w_ptr_n;
            r_remaining <= w_remaining_n;
            r_cur_addr  <= w_cur_addr_n;
            r_gnt_a     <= w_gnt_a_n;
            r_gnt_b     <= w_gnt_b_n;
            r_valid_a   <= w_valid_a_n;
            r_valid_b   <= w_valid_b_n;
            r_last      <= w_last_n;
            r_busy      <= w_busy_n;
            r_data      <= w_data_n;
        end
    end

    // The address register doubles as the bank address, so it holds outside ISSUE
    assign o_reg_addr    = r_cur_addr;
    assign o_reg_wr      = 1'b0;
    assign o_gnt_a       = r_gnt_a;
    assign o_gnt_b       = r_gnt_b;
    assign o_rsp_valid_a = r_valid_a;
    assign o_rsp_valid_b = r_valid_b;
    assign o_rsp_last    = r_last;
    assign o_rsp_data    = r_data;
    assign o_busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_thunderbolt_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_thunderbolt_reg_arbiter
// Brief    : Scoreboard bench for thunderbolt_reg_arbiter with a bank model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_thunderbolt_reg_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_a = 1'b0, req_b = 1'b0;
    logic [6:0] addr_a = '0, addr_b = '0;
    logic [3:0] len_a = '0, len_b = '0;
    logic       ready_a = 1'b0, ready_b = 1'b0;
    logic       gnt_a, gnt_b, valid_a, valid_b, last, busy, reg_wr;
    logic [7:0] rsp_data;
    logic [6:0] reg_addr;
    logic [7:0] reg_data = '0;
    logic [7:0] mem [128];

    thunderbolt_reg_arbiter #(.ADDR_W(7), .DATA_W(8)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_a(req_a), .i_req_b(req_b),
        .i_addr_a(addr_a), .i_addr_b(addr_b),
        .i_len_a(len_a), .i_len_b(len_b),
        .o_gnt_a(gnt_a), .o_gnt_b(gnt_b),
        .o_rsp_valid_a(valid_a), .o_rsp_valid_b(valid_b),
        .i_rsp_ready_a(ready_a), .i_rsp_ready_b(ready_b),
        .o_rsp_data(rsp_data), .o_rsp_last(last), .o_busy(busy),
        .o_reg_wr(reg_wr), .o_reg_addr(reg_addr), .i_reg_data(reg_data)
    );

    always #5 clk = ~clk;

    // Bank read port: registered data, one cycle behind the address
    always @(posedge clk) reg_data <= mem[reg_addr];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Reference model: one expected entry per returned byte
    typedef struct {
        bit       owner;
        bit [6:0] addr;
        bit [7:0] data;
        bit       last;
    } exp_t;

    exp_t sb[$];
    bit   grant_log[$];
    bit   m_busy = 0, m_ptr_b = 0, m_hold = 0, m_owner = 0;
    bit   exp_gnt_a = 0, exp_gnt_b = 0;
    int   m_cnt = 0;
    bit   was_idle, pick_b;
    int   n_bytes;
    bit [6:0] base;
    exp_t e;

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 0; m_ptr_b = 0; m_hold = 0;
            exp_gnt_a = 0; exp_gnt_b = 0;
            sb.delete();
        end else begin
            was_idle = !m_busy;
            check("reg_wr", reg_wr, 0);
            check("busy", busy, m_busy);
            check("gnt_a", gnt_a, exp_gnt_a);
            check("gnt_b", gnt_b, exp_gnt_b);
            exp_gnt_a = 0;
            exp_gnt_b = 0;
            if (!m_busy) begin
                check("valid_a_idle", valid_a, 0);
                check("valid_b_idle", valid_b, 0);
            end else if (!m_hold) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_hold = 1;
                end else begin
                    check("valid_a_early", valid_a, 0);
                    check("valid_b_early", valid_b, 0);
                end
            end
            if (m_busy && m_hold) begin
                check("valid_owner", m_owner ? valid_b : valid_a, 1);
                check("valid_other", m_owner ? valid_a : valid_b, 0);
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_underflow: byte presented with nothing expected at %0t", $time);
                end else begin
                    e = sb[0];
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_last", last, e.last);
                    check("reg_addr", reg_addr, e.addr);
                    if (m_owner ? ready_b : ready_a) begin
                        void'(sb.pop_front());
                        if (e.last) begin
                            m_busy = 0;
                        end else begin
                            m_hold = 0;
                            m_cnt  = 3;
                        end
                    end
                end
            end
            if (was_idle && (req_a || req_b)) begin
                pick_b    = req_b && (!req_a || m_ptr_b);
                exp_gnt_a = !pick_b;
                exp_gnt_b = pick_b;
                m_ptr_b   = !pick_b;
                m_owner   = pick_b;
                m_busy    = 1;
                m_hold    = 0;
                m_cnt     = 3;
                base      = pick_b ? addr_b : addr_a;
                n_bytes   = ((pick_b ? len_b : len_a) == 4'd0) ? 16 : int'(pick_b ? len_b : len_a);
                for (int i = 0; i < n_bytes; i++) begin
                    e.owner = pick_b;
                    e.addr  = 7'((int'(base) + i) % 128);
                    e.data  = mem[e.addr];
                    e.last  = (i == n_bytes - 1);
                    sb.push_back(e);
                end
                grant_log.push_back(pick_b);
            end
        end
    end

    // 0: ready held high, 1: random ready, 2: driven by the main sequence
    int ready_mode = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) begin
                ready_a = 1'b1;
                ready_b = 1'b1;
            end else if (ready_mode == 1) begin
                ready_a = ($urandom_range(0, 3) != 0);
                ready_b = ($urandom_range(0, 3) != 0);
            end
        end
    end

    task automatic do_req(input bit side, input logic [6:0] a, input logic [3:0] l);
        int t;
        @(posedge clk);
        #1;
        if (side) begin req_b = 1'b1; addr_b = a; len_b = l; end
        else      begin req_a = 1'b1; addr_a = a; len_a = l; end
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (((side ? gnt_b : gnt_a) !== 1'b1) && t < 1000);
        if (t >= 1000) fail_now(side ? "grant_wait_b" : "grant_wait_a");
        @(posedge clk);
        #1;
        if (side) req_b = 1'b0;
        else      req_a = 1'b0;
    endtask

    task automatic req_loop(input bit side, input int n, input int max_gap);
        for (int k = 0; k < n; k++) begin
            do_req(side, 7'($urandom), 4'($urandom));
            repeat ($urandom_range(0, max_gap)) @(posedge clk);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((m_busy || sb.size() != 0 || req_a || req_b) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) fail_now("drain");
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_valid(input bit side);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (((side ? valid_b : valid_a) !== 1'b1) && t < 100);
        if (t >= 100) fail_now(side ? "valid_wait_b" : "valid_wait_a");
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt_a"}, gnt_a, 0);
        check({tag, "_gnt_b"}, gnt_b, 0);
        check({tag, "_valid_a"}, valid_a, 0);
        check({tag, "_valid_b"}, valid_b, 0);
        check({tag, "_last"}, last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_reg_wr"}, reg_wr, 0);
        check({tag, "_data"}, rsp_data, 0);
        check({tag, "_reg_addr"}, reg_addr, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = (i % 9 == 0) ? 8'h00 : 8'($urandom);
        mem[7]  = 8'hE8; mem[8]  = 8'h07; mem[9]  = 8'h03; mem[10] = 8'h15;
        mem[11] = 8'h12; mem[12] = 8'h34; mem[13] = 8'h56;

        #1 rst = 1'b1;
        #1 check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Contention from reset: both request back to back, grants must alternate
        ready_mode = 0;
        grant_log.delete();
        fork
            req_loop(0, 3, 0);
            req_loop(1, 3, 0);
        join
        wait_idle();
        check("contention_count", grant_log.size(), 6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            check("contention_order", grant_log[i], i % 2);

        // Single read, then the seven-byte time field burst
        do_req(0, 7'h07, 4'd1);
        wait_idle();
        do_req(0, 7'h07, 4'd7);
        wait_idle();

        // Backpressure on byte 2 of a three-byte burst
        ready_mode = 2;
        ready_a = 1'b1;
        ready_b = 1'b0;
        do_req(0, 7'h20, 4'd3);
        wait_valid(0);
        @(posedge clk);
        #1 ready_a = 1'b0;
        wait_valid(0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1 ready_a = 1'b1;
        wait_idle();

        // Wrap from 0x7F with length 0 (16 bytes)
        ready_mode = 0;
        do_req(1, 7'h7F, 4'd0);
        wait_idle();

        // Reset during HOLD of byte 2
        ready_mode = 2;
        ready_a = 1'b1;
        ready_b = 1'b0;
        do_req(1, 7'h10, 4'd4);
        wait_valid(1);
        @(posedge clk);
        #1 ready_b = 1'b1;
        @(posedge clk);
        #1 ready_b = 1'b0;
        wait_valid(1);
        #2 rst = 1'b1;
        #1 check_all_zero("midrst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        ready_mode = 0;
        grant_log.delete();
        do_req(1, 7'h05, 4'd2);
        wait_idle();
        check("post_reset_grant_b", (grant_log.size() == 1) ? 32'(grant_log[0]) : 32'hFF, 1);

        // Randomized contention with random backpressure
        ready_mode = 1;
        fork
            req_loop(0, 15, 4);
            req_loop(1, 15, 4);
        join
        ready_mode = 0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/thunderbolt_reg_arbiter.md
# thunderbolt_reg_arbiter

Read controller that shares the Thunderbolt time register bank between two requesters: A (host SPI slave) and B (UART command engine). It grants one requester at a time using round-robin arbitration. For the granted requester it sequences single-byte or burst reads over consecutive bank addresses, and returns each byte through a valid/ready handshake. It sits between the two command front-ends and the bank's read port, and is the only master of that port.

## Interface
- ADDR_W, 7, bank address width
- DATA_W, 8, bank data width
- i_clk  input  1  system clock; all logic on rising edge
- i_rst  input  1  reset, asynchronous, active-high
- i_req_a / i_req_b  input  1  read request; held with address/length until grant
- i_addr_a / i_addr_b  input  ADDR_W  burst start address
- i_len_a / i_len_b  input  4  burst length in bytes; 0 means 16
- o_gnt_a / o_gnt_b  output  1  one-cycle grant pulse; request captured
- o_rsp_valid_a / o_rsp_valid_b  output  1  response byte valid for that requester
- i_rsp_ready_a / i_rsp_ready_b  input  1  requester accepts the byte
- o_rsp_data  output  DATA_W  response byte, shared by both requesters
- o_rsp_last  output  1  qualifies the final byte of the burst
- o_busy  output  1  high in any state other than IDLE
- o_reg_wr  output  1  bank write strobe; held 0 at all times
- o_reg_addr  output  ADDR_W  bank read address
- i_reg_data  input  DATA_W  bank read data; registered, one-cycle latency

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, HOLD.
- IDLE
  - Requests are sampled only in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the side named by the priority pointer (ptr).
  - On grant: latch addr and len (0→16) into cur_addr and remaining, record owner, pulse o_gnt_x, go to ISSUE.
  - After a grant, ptr points to the other requester. Reset value of ptr is A.
- A request dropped before grant is ignored; no grant is issued.
- ISSUE: drive o_reg_addr = cur_addr; go to CAPTURE.
- CAPTURE
  - i_reg_data now holds data for cur_addr; register it into o_rsp_data.
  - Set o_rsp_valid_<owner> = 1 and o_rsp_last = (remaining == 1).
  - Go to HOLD.
- HOLD
  - Hold data, valid and last until ready from the owner is high at a clock edge.
  - On that handshake, drop valid.
  - If last: clear o_busy and go to IDLE.
  - Otherwise: cur_addr += 1 (modulo 2^ADDR_W, so 0x7F wraps to 0x00), remaining -= 1, go to ISSUE.
- The non-owner's ready is ignored, and its valid stays 0.
- o_reg_addr holds its last value outside ISSUE. The bank output is don't-care outside CAPTURE.
- Unmapped bank addresses return whatever the bank drives (0x00); this block passes it through unchanged.
- Reset values: state IDLE, all o_gnt_*, o_rsp_valid_*, o_rsp_last, o_busy, o_reg_wr = 0; o_rsp_data = 0x00; o_reg_addr = 0x00; ptr = A.
- Reset asserted mid-burst aborts immediately. The in-flight byte is lost, and no valid is asserted until a new grant.

## Timing
- All outputs are registered.
- Single-byte read, request high in cycle 0 (IDLE):
  - cycle 1: o_gnt pulse; state ISSUE; o_reg_addr valid.
  - cycle 2: CAPTURE.
  - cycle 3: o_rsp_valid high.
- Minimum per-byte period with ready held high is 3 cycles (ISSUE, CAPTURE, HOLD).
- A new grant is possible in the cycle after the final handshake edge, since the FSM is back in IDLE.
- A request presented during a busy burst waits. It is arbitrated on the first IDLE cycle.

## Test plan
- Single read, with the bank holding year_l = 0xE8 at 0x07: A requests addr 0x07, len 1, ready high → o_gnt_a in cycle 1; o_rsp_valid_a in cycle 3 with data 0xE8 and last = 1; o_busy low in cycle 4.
- Burst, with the bank loaded with time fields 0x07..0x0D: A requests addr 0x07, len 7 → seven bytes returned in address order; last only on the seventh; o_reg_addr steps 0x07→0x0D.
- Contention from reset: A and B both request continuously → grants alternate A, B, A; o_rsp_valid_b never high during A's burst.
- Backpressure: during a len-3 burst, hold ready low for 5 cycles on byte 2 → data, valid and last stable throughout; o_reg_addr does not advance; byte 3 follows normally.
- Wrap and length 0: B requests addr 0x7F, len 0 → 16 reads at addresses 0x7F, 0x00, …, 0x0E; last on the 16th; o_reg_wr stays 0 throughout.
- Reset mid-burst: assert i_rst asynchronously during HOLD of byte 2 → all outputs 0 immediately; after release, a B request is granted (ptr = A, but A is not requesting) with normal latency.
